lcd_scanout_reader: RTL
=======================

Name: lcd_scanout_reader

Overview:
- Read-side consumer of the palette pixel FIFO; drives the RGB parallel LCD panel.
- Generates panel timing: dclk, hsync, vsync, den, disp.
- Pops one RGB888 word per active pixel from the first-word-fall-through (FWFT) FIFO and presents it on the panel pins.
- Sits in the clk_lcd domain, opposite the pipeline-side FIFO writer; flags underflow when the pipeline cannot keep pace.

Parameters:
- H_SYNC, 41, hsync pulse width in pixels
- H_BP, 2, horizontal back porch in pixels
- H_ACTIVE, 480, visible pixels per line
- H_FP, 2, horizontal front porch in pixels
- V_SYNC, 10, vsync pulse width in lines
- V_BP, 2, vertical back porch in lines
- V_ACTIVE, 272, visible lines per frame
- V_FP, 4, vertical front porch in lines
- START_LEVEL, 8, minimum FIFO occupancy before the first frame starts

Ports:
- clk_lcd  in  1  LCD clock, 15 MHz max; pixel rate = clk_lcd/2
- rst  in  1  asynchronous, active-low reset
- enable  in  1  1 = run display, 0 = stop at next frame boundary
- clearUnderflow  in  1  single-cycle pulse, clears underflow
- bufferEmpty  in  1  FIFO empty flag
- bufferSize  in  8  FIFO occupancy
- fifoData  in  24  FWFT head word {R,G,B}
- readEn  out  1  FIFO pop strobe (combinational)
- red/green/blue  out  8 each  panel color pins
- dclk  out  1  panel pixel clock
- disp  out  1  panel display enable
- hsync  out  1  active-low line sync
- vsync  out  1  active-low frame sync
- den  out  1  active-high data enable
- frameStart  out  1  one-cycle pulse at start of every frame
- underflow  out  1  sticky: an active pixel found the FIFO empty

Behaviour:
- Reset values:
  - rgb 0, dclk 0, disp 0, den 0, readEn 0, frameStart 0, underflow 0.
  - hsync 1, vsync 1.
  - Counters 0; state OFF.
  - Reset mid-frame aborts immediately to these values.
- Phase register:
  - Toggles every clk_lcd cycle while state != OFF; dclk = phase.
  - Pixel tick = cycle where phase == 1.
  - All pin outputs update only on the tick edge (dclk falling), so they are stable at dclk rising.
- Counters:
  - hCount runs 0..H_TOTAL-1 (H_TOTAL = sum of the H parameters), advancing on each tick.
  - vCount runs 0..V_TOTAL-1, advancing when hCount wraps.
  - Region order, from count 0: sync, back porch, active, front porch.
- Registered pin values for the pixel at (hCount, vCount):
  - hsync = 0 iff hCount < H_SYNC.
  - vsync = 0 iff vCount < V_SYNC.
  - den = 1 iff both counts lie in their active regions.
- FIFO read:
  - readEn = tick AND next pixel active AND !bufferEmpty AND state == RUN.
  - fifoData is captured into rgb on that same edge (FWFT, pop on the edge).
  - At most one pop per pixel; never a pop outside active pixels.
- Underflow:
  - An active pixel with bufferEmpty = 1 outputs rgb = 0 and sets underflow.
  - No pop occurs for that pixel and the counters do not stall.
  - clearUnderflow clears the flag; if clear and set coincide, set wins.
- Non-active pixels drive rgb = 0.
- State machine:
  - OFF: disp 0, phase held 0.
    - enable = 1 -> PRIME.
  - PRIME: disp 1, dclk toggling, syncs held inactive, counters held at 0.
    - bufferSize >= START_LEVEL -> RUN, frameStart pulses on the entry cycle.
    - enable = 0 -> OFF.
  - RUN: normal scanout.
    - At counter wrap to (0,0), frameStart pulses.
    - If enable = 0 at the wrap: -> OFF; the frame in progress always completes.
- Simultaneous events: enable dropping exactly on the wrap cycle stops at that wrap; no further frame starts.
- Frame length: exactly H_TOTAL*V_TOTAL ticks, independent of FIFO state.

Decomposition:
- Shared package lcd_pkg:
  - timing default constants;
  - derived H_TOTAL and V_TOTAL;
  - state enum {OFF, PRIME, RUN};
  - counter width constants (11 bits each).
- One sub-module, lcd_sync_counter:
  - inputs: tick, hold;
  - outputs: hCount, vCount, wrap, inHActive, inVActive, inHSync, inVSync.

Test Plan:
- Bench parameters: H = 1/1/4/1, V = 1/1/3/1, START_LEVEL = 2.
- Reset/OFF: rst low mid-frame -> next cycle hsync=vsync=1, den=0, disp=0, rgb=0, readEn=0.
- Prime gating: enable=1 with bufferSize=1 -> disp=1, dclk toggles, no frameStart, no readEn. Raise to 2 -> frameStart one cycle, RUN entered.
- Full frame: FIFO preloaded 0x000001..0x00000C ->
  - exactly 12 readEn pulses;
  - den high for 4 ticks on each of 3 lines;
  - rgb sequence matches the preload;
  - hsync low 1 tick/line, vsync low 1 line;
  - frame = 7*6 = 42 ticks.
- Underflow: only 5 words available ->
  - pixels 6..12 output rgb=0 with no readEn;
  - underflow=1 and sticky;
  - clearUnderflow during blanking -> 0;
  - clear and set on the same cycle -> stays 1.
- Stop: drop enable mid-frame -> frame completes to tick 42, then OFF with disp=0. Drop enable on the wrap cycle -> no frameStart follows.
- Back-to-back frames: FIFO kept non-empty -> frameStart every 84 clk_lcd cycles; underflow stays 0.

Source files
------------

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared timing defaults, state encoding and pin bundle for the LCD scanout reader
package lcd_pkg;

    localparam int CNT_W = 11;
    localparam int RGB_W = 24;

    localparam int DEF_H_SYNC      = 41;
    localparam int DEF_H_BP        = 2;
    localparam int DEF_H_ACTIVE    = 480;
    localparam int DEF_H_FP        = 2;
    localparam int DEF_V_SYNC      = 10;
    localparam int DEF_V_BP        = 2;
    localparam int DEF_V_ACTIVE    = 272;
    localparam int DEF_V_FP        = 4;
    localparam int DEF_START_LEVEL = 8;

    localparam int H_TOTAL = DEF_H_SYNC + DEF_H_BP + DEF_H_ACTIVE + DEF_H_FP;
    localparam int V_TOTAL = DEF_V_SYNC + DEF_V_BP + DEF_V_ACTIVE + DEF_V_FP;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } lcd_state_e;

    // Everything that changes on a pixel tick, registered as one bundle.
    typedef struct packed {
        logic             hsync_n;
        logic             vsync_n;
        logic             den;
        logic [RGB_W-1:0] rgb;
    } lcd_pins_t;

    localparam lcd_pins_t PINS_IDLE = '{hsync_n: 1'b1, vsync_n: 1'b1, den: 1'b0, rgb: 24'd0};

    // Half-open interval test [lo, hi).
    function automatic logic in_range(input logic [CNT_W-1:0] cnt,
                                      input logic [CNT_W-1:0] lo,
                                      input logic [CNT_W-1:0] hi);
        return (cnt >= lo) && (cnt < hi);
    endfunction

endpackage

// File: rtl/lcd_sync_counter.sv
// rtl/lcd_sync_counter.sv - horizontal/vertical pixel counters with region decode for panel timing
module lcd_sync_counter
    import lcd_pkg::*;
#(
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP
) (
    input  logic             clk_lcd,
    input  logic             rst,
    input  logic             tick,
    input  logic             hold,
    output logic [CNT_W-1:0] hCount,
    output logic [CNT_W-1:0] vCount,
    output logic             wrap,
    output logic             inHActive,
    output logic             inVActive,
    output logic             inHSync,
    output logic             inVSync
);

    localparam logic [CNT_W-1:0] H_SYNC_HI = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] H_ACT_LO  = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] H_ACT_HI  = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
    localparam logic [CNT_W-1:0] V_SYNC_HI = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] V_ACT_LO  = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] V_ACT_HI  = CNT_W'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             h_last, v_last;

    assign h_last = (h_cnt_q == H_LAST);
    assign v_last = (v_cnt_q == V_LAST);
    assign wrap   = tick && !hold && h_last && v_last;

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (hold) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (tick) begin
            if (h_last) begin
                h_cnt_d = '0;
                v_cnt_d = v_last ? '0 : v_cnt_q + CNT_W'(1);
            end else begin
                h_cnt_d = h_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_lcd or negedge rst) begin
        if (!rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign hCount    = h_cnt_q;
    assign vCount    = v_cnt_q;
    assign inHSync   = (h_cnt_q < H_SYNC_HI);
    assign inVSync   = (v_cnt_q < V_SYNC_HI);
    assign inHActive = in_range(h_cnt_q, H_ACT_LO, H_ACT_HI);
    assign inVActive = in_range(v_cnt_q, V_ACT_LO, V_ACT_HI);

endmodule

// File: rtl/lcd_scanout_reader.sv
// rtl/lcd_scanout_reader.sv - FWFT pixel FIFO reader driving RGB parallel panel timing and data pins
module lcd_scanout_reader
    import lcd_pkg::*;
#(
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FP        = DEF_H_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FP        = DEF_V_FP,
    parameter int START_LEVEL = DEF_START_LEVEL
) (
    input  logic             clk_lcd,
    input  logic             rst,
    input  logic             enable,
    input  logic             clearUnderflow,
    input  logic             bufferEmpty,
    input  logic [7:0]       bufferSize,
    input  logic [RGB_W-1:0] fifoData,
    output logic             readEn,
    output logic [7:0]       red,
    output logic [7:0]       green,
    output logic [7:0]       blue,
    output logic             dclk,
    output logic             disp,
    output logic             hsync,
    output logic             vsync,
    output logic             den,
    output logic             frameStart,
    output logic             underflow
);

    localparam logic [7:0] START_LVL = 8'(START_LEVEL);

    lcd_state_e       state_q;
    logic             phase_q;
    logic             disp_q;
    logic             frame_start_q;
    logic             underflow_q, underflow_d;
    lcd_pins_t        pins_q, pins_d;

    logic [CNT_W-1:0] h_count, v_count;
    logic             wrap;
    logic             in_h_active, in_v_active, in_h_sync, in_v_sync;
    logic             run, tick, pix_active, at_origin, underflow_set;

    assign run        = (state_q == ST_RUN);
    assign tick       = phase_q;
    assign pix_active = in_h_active && in_v_active;
    assign at_origin  = (h_count == '0) && (v_count == '0);

    lcd_sync_counter #(
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP)
    ) u_sync_counter (
        .clk_lcd   (clk_lcd),
        .rst       (rst),
        .tick      (tick && run),
        .hold      (!run),
        .hCount    (h_count),
        .vCount    (v_count),
        .wrap      (wrap),
        .inHActive (in_h_active),
        .inVActive (in_v_active),
        .inHSync   (in_h_sync),
        .inVSync   (in_v_sync)
    );

    // FWFT: the head word is valid while non-empty and is consumed on the pop edge.
    assign readEn        = tick && pix_active && !bufferEmpty && run;
    assign underflow_set = tick && pix_active && bufferEmpty && run;

    always_comb begin
        underflow_d = underflow_q;
        if (underflow_set) begin
            underflow_d = 1'b1;
        end else if (clearUnderflow) begin
            underflow_d = 1'b0;
        end
    end

    always_comb begin
        pins_d         = PINS_IDLE;
        pins_d.hsync_n = !in_h_sync;
        pins_d.vsync_n = !in_v_sync;
        pins_d.den     = pix_active;
        pins_d.rgb     = readEn ? fifoData : '0;
    end

    always_ff @(posedge clk_lcd or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_OFF;
            phase_q       <= 1'b0;
            disp_q        <= 1'b0;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
            pins_q        <= PINS_IDLE;
        end else begin
            underflow_q   <= underflow_d;
            frame_start_q <= 1'b0;
            unique case (state_q)
                ST_OFF: begin
                    phase_q <= 1'b0;
                    pins_q  <= PINS_IDLE;
                    disp_q  <= enable;
                    if (enable) begin
                        state_q <= ST_PRIME;
                    end
                end
                ST_PRIME: begin
                    pins_q <= PINS_IDLE;
                    if (!enable) begin
                        state_q <= ST_OFF;
                        disp_q  <= 1'b0;
                        phase_q <= 1'b0;
                    end else begin
                        phase_q <= ~phase_q;
                        // Enter RUN on a tick edge so every frame starts with dclk low.
                        if (tick && at_origin && (bufferSize >= START_LVL)) begin
                            state_q       <= ST_RUN;
                            frame_start_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    phase_q <= ~phase_q;
                    if (tick) begin
                        if (wrap && !enable) begin
                            state_q <= ST_OFF;
                            disp_q  <= 1'b0;
                            phase_q <= 1'b0;
                            pins_q  <= PINS_IDLE;
                        end else begin
                            pins_q        <= pins_d;
                            frame_start_q <= wrap;
                        end
                    end
                end
                default: begin
                    state_q <= ST_OFF;
                    disp_q  <= 1'b0;
                    phase_q <= 1'b0;
                    pins_q  <= PINS_IDLE;
                end
            endcase
        end
    end

    assign red        = pins_q.rgb[23:16];
    assign green      = pins_q.rgb[15:8];
    assign blue       = pins_q.rgb[7:0];
    assign hsync      = pins_q.hsync_n;
    assign vsync      = pins_q.vsync_n;
    assign den        = pins_q.den;
    assign dclk       = phase_q;
    assign disp       = disp_q;
    assign frameStart = frame_start_q;
    assign underflow  = underflow_q;

endmodule
